// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: merges NCH level-held memory requesters onto one shared
// memory port. Arbitration is round-robin (RR=1) or fixed priority (RR=0,
// lowest index wins). Within a channel a pending read beats a pending write.
// An optional response timeout (TMO>0) forces a completion flagged on s_err.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_read_req/w/hw/adr         per-channel read request, size, address (packed)
//   s_read_valid, s_read_data   one-cycle read completion to the granted channel
//   s_write_req/w/hw/adr/data   per-channel write request (packed)
//   s_write_finish              one-cycle write completion
//   s_err                       one-cycle timeout flag, with the forced completion
//   m_read_*/m_write_*          shared downstream memory port
//   busy                        high whenever the arbiter is not idle
module mem_bus_arbiter #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned RR    = 1,
  parameter int unsigned TMO   = 0,
  parameter int unsigned TMO_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    s_read_req,
  input  logic [NCH-1:0]    s_read_w,
  input  logic [NCH-1:0]    s_read_hw,
  input  logic [NCH*AW-1:0] s_read_adr,
  output logic [NCH-1:0]    s_read_valid,
  output logic [DW-1:0]     s_read_data,
  input  logic [NCH-1:0]    s_write_req,
  input  logic [NCH-1:0]    s_write_w,
  input  logic [NCH-1:0]    s_write_hw,
  input  logic [NCH*AW-1:0] s_write_adr,
  input  logic [NCH*DW-1:0] s_write_data,
  output logic [NCH-1:0]    s_write_finish,
  output logic [NCH-1:0]    s_err,
  output logic              m_read_req,
  output logic              m_read_w,
  output logic              m_read_hw,
  output logic [AW-1:0]     m_read_adr,
  input  logic              m_read_valid,
  input  logic [DW-1:0]     m_read_data,
  output logic              m_write_req,
  output logic              m_write_w,
  output logic              m_write_hw,
  output logic [AW-1:0]     m_write_adr,
  output logic [DW-1:0]     m_write_data,
  input  logic              m_write_finish,
  output logic              busy
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO > 0) ? TMO - 1 : 0);

  typedef enum logic [1:0] {IDLE, RD, WR, HOLD} state_t;

  state_t           state;
  logic [GW-1:0]    gnt;
  logic [GW-1:0]    last_gnt;
  logic [TMO_W-1:0] tcnt;

  logic [NCH-1:0]   elig;
  logic             win_found;
  logic [GW-1:0]    win_idx;
  int unsigned      idx;
  logic             tmo_hit;
  logic             rd_resp, rd_tmo, wr_resp, wr_tmo;

  logic [AW-1:0]    rd_adr_a [NCH];
  logic [AW-1:0]    wr_adr_a [NCH];
  logic [DW-1:0]    wr_dat_a [NCH];

  // Unpack the flat per-channel buses so the granted channel can be selected by index
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign rd_adr_a[i] = s_read_adr[i*AW +: AW];
    assign wr_adr_a[i] = s_write_adr[i*AW +: AW];
    assign wr_dat_a[i] = s_write_data[i*DW +: DW];
  end

  assign elig = s_read_req | s_write_req;

  // Winner search: round-robin scans from last_gnt+1, fixed priority from 0
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = (RR != 0) ? (32'(last_gnt) + 32'd1 + k) % NCH : k;
      if (!win_found && elig[GW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  // A real response in the timeout cycle takes precedence over the timeout
  always_comb begin
    tmo_hit = (TMO != 0) && (tcnt == TMO_LAST);
    rd_resp = (state == RD) && m_read_valid;
    rd_tmo  = (state == RD) && !m_read_valid && tmo_hit;
    wr_resp = (state == WR) && m_write_finish;
    wr_tmo  = (state == WR) && !m_write_finish && tmo_hit;
  end

  // Downstream port follows the granted channel; completions return combinationally
  always_comb begin
    m_read_req     = (state == RD);
    m_read_w       = s_read_w[gnt];
    m_read_hw      = s_read_hw[gnt];
    m_read_adr     = rd_adr_a[gnt];
    m_write_req    = (state == WR);
    m_write_w      = s_write_w[gnt];
    m_write_hw     = s_write_hw[gnt];
    m_write_adr    = wr_adr_a[gnt];
    m_write_data   = wr_dat_a[gnt];
    s_read_valid   = '0;
    s_write_finish = '0;
    s_err          = '0;
    s_read_data    = rd_resp ? m_read_data : '0;
    busy           = (state != IDLE);
    if (rd_resp || rd_tmo) s_read_valid[gnt]   = 1'b1;
    if (wr_resp || wr_tmo) s_write_finish[gnt] = 1'b1;
    if (rd_tmo || wr_tmo)  s_err[gnt]          = 1'b1;
  end

  // Control FSM; HOLD gives the requester a cycle to drop its level request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= GW'(NCH - 1);
      tcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt      <= win_idx;
            last_gnt <= win_idx;
            tcnt     <= '0;
            state    <= s_read_req[win_idx] ? RD : WR;
          end
        end
        RD: begin
          if (rd_resp || rd_tmo) state <= HOLD;
          else                   tcnt  <= tcnt + TMO_W'(1);
        end
        WR: begin
          if (wr_resp || wr_tmo) state <= HOLD;
          else                   tcnt  <= tcnt + TMO_W'(1);
        end
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
